ws2812b_rx_decoder: RTL and testbench

WS2812B_RX_DECODER -- requirements
Module: ws2812b_rx_decoder

---
 rtl/ws2812b_pkg.sv | 17 +
 rtl/ws2812b_din_sync.sv | 28 ++
 rtl/ws2812b_rx_decoder.sv | 147 ++++++++++++++
 tb/tb_ws2812b_rx_decoder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ws2812b_pkg.sv
// WS2812B line timing shared by the transmitter and the receive decoder.
// High-time thresholds are in clk cycles at 40 MHz.
package ws2812b_pkg;
   localparam int T_HIGH_MIN       = 8;
   localparam int T_BIT_THRESH     = 24;
   localparam int T_HIGH_MAX       = 56;
   localparam int RESET_CYCLES_DEF = 1600;
   localparam int GRB_W            = 24;

   typedef enum logic [2:0] {
      SYNC,
      WAIT_RISE,
      HIGH,
      LOW,
      ERR
   } rx_state_t;
endpackage

// File: rtl/ws2812b_din_sync.sv
// Two-flop synchronizer for the WS2812B line plus one edge-detect register.
// rise/fall are single-cycle strobes aligned with the synchronized level din_s.
module ws2812b_din_sync (
   input  logic clk,
   input  logic res_n,
   input  logic din,
   output logic din_s,
   output logic rise,
   output logic fall
);
   logic din_p0, din_p1, din_p2;

   always_ff @(posedge clk) begin
      if (!res_n) begin
         din_p0 <= 1'b0;
         din_p1 <= 1'b0;
         din_p2 <= 1'b0;
      end else begin
         din_p0 <= din;
         din_p1 <= din_p0;
         din_p2 <= din_p1;
      end
   end

   assign din_s = din_p1;
   assign rise  = din_p1 & ~din_p2;
   assign fall  = ~din_p1 & din_p2;
endmodule

// File: rtl/ws2812b_rx_decoder.sv
// WS2812B receive decoder: measures high pulse widths to recover GRB pixels,
// tracks pixel position per frame and publishes a lit-pixel mask at each reset gap.
module ws2812b_rx_decoder
   import ws2812b_pkg::*;
#(
   parameter int NUM_LEDS     = 12,
   parameter int RESET_CYCLES = RESET_CYCLES_DEF
) (
   input  logic                clk,
   input  logic                res_n,
   input  logic                din,
   output logic [23:0]         pix_data,
   output logic                pix_valid,
   output logic [3:0]          pix_index,
   output logic                frame_done,
   output logic [NUM_LEDS-1:0] rx_led_mask,
   output logic                rx_err
);
   localparam logic [10:0] LOW_LAST = 11'(RESET_CYCLES - 1);

   // Returns {error, bit} for a measured high time (width minus one).
   function automatic logic [1:0] classify(input logic [5:0] cnt);
      if (cnt < 6'(T_HIGH_MIN) || cnt > 6'(T_HIGH_MAX)) return 2'b10;
      else if (cnt < 6'(T_BIT_THRESH))                   return 2'b00;
      else                                               return 2'b01;
   endfunction

   logic din_s, rise, fall;

   ws2812b_din_sync u_sync (
      .clk   (clk),
      .res_n (res_n),
      .din   (din),
      .din_s (din_s),
      .rise  (rise),
      .fall  (fall)
   );

   rx_state_t           state;
   logic [5:0]          high_cnt;
   logic [10:0]         low_cnt;
   logic [4:0]          bit_cnt;
   logic [3:0]          pix_cnt;
   logic                have_pix;
   logic [23:0]         shift;
   logic [NUM_LEDS-1:0] work_mask;
   logic [1:0]          cls;
   logic [23:0]         shift_nx;

   assign cls      = classify(high_cnt);
   assign shift_nx = {shift[22:0], cls[0]};

   always_ff @(posedge clk) begin
      if (!res_n) begin
         state       <= SYNC;
         high_cnt    <= '0;
         low_cnt     <= '0;
         bit_cnt     <= '0;
         pix_cnt     <= '0;
         have_pix    <= 1'b0;
         work_mask   <= '0;
         pix_data    <= '0;
         pix_index   <= '0;
         pix_valid   <= 1'b0;
         frame_done  <= 1'b0;
         rx_err      <= 1'b0;
         rx_led_mask <= '0;
      end else begin
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         rx_err     <= 1'b0;
         case (state)
            SYNC, ERR: begin
               if (din_s) low_cnt <= '0;
               else if (low_cnt >= LOW_LAST) begin
                  low_cnt <= '0;
                  state   <= WAIT_RISE;
               end else low_cnt <= low_cnt + 11'd1;
            end
            WAIT_RISE: begin
               if (rise) begin
                  high_cnt <= '0;
                  state    <= HIGH;
               end
            end
            HIGH: begin
               if (fall && !cls[1]) begin
                  shift   <= shift_nx;
                  low_cnt <= '0;
                  state   <= LOW;
                  if (bit_cnt == 5'(GRB_W - 1)) begin
                     bit_cnt   <= '0;
                     pix_data  <= shift_nx;
                     pix_index <= pix_cnt;
                     pix_valid <= 1'b1;
                     have_pix  <= 1'b1;
                     if (pix_cnt != 4'hf) pix_cnt <= pix_cnt + 4'd1;
                     // Positions beyond NUM_LEDS never match, so they leave the mask alone.
                     for (int i = 0; i < NUM_LEDS; i++)
                        if (int'(pix_cnt) == i && shift_nx != '0) work_mask[i] <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end else if (fall || high_cnt > 6'(T_HIGH_MAX)) begin
                  rx_err    <= 1'b1;
                  work_mask <= '0;
                  bit_cnt   <= '0;
                  pix_cnt   <= '0;
                  pix_index <= '0;
                  have_pix  <= 1'b0;
                  low_cnt   <= '0;
                  state     <= ERR;
               end else if (high_cnt != 6'h3f) begin
                  high_cnt <= high_cnt + 6'd1;
               end
            end
            LOW: begin
               if (rise) begin
                  high_cnt <= '0;
                  state    <= HIGH;
               end else if (low_cnt >= LOW_LAST) begin
                  low_cnt   <= '0;
                  work_mask <= '0;
                  pix_cnt   <= '0;
                  pix_index <= '0;
                  have_pix  <= 1'b0;
                  if (bit_cnt != '0) begin
                     // A gap inside a pixel: drop the whole frame and resynchronise.
                     rx_err  <= 1'b1;
                     bit_cnt <= '0;
                     state   <= ERR;
                  end else begin
                     if (have_pix) begin
                        frame_done  <= 1'b1;
                        rx_led_mask <= work_mask;
                     end
                     state <= WAIT_RISE;
                  end
               end else begin
                  low_cnt <= low_cnt + 11'd1;
               end
            end
            default: state <= SYNC;
         endcase
      end
   end
endmodule

// File: tb/tb_ws2812b_rx_decoder.sv
// Scoreboard bench for ws2812b_rx_decoder: drives WS2812B bit streams on din and
// compares every pixel strobe, frame mask and error strobe against queued expectations.
`timescale 1ns/1ps
module tb_ws2812b_rx_decoder;
   logic        clk = 1'b0;
   logic        res_n;
   logic        din;
   logic [23:0] pix_data;
   logic        pix_valid;
   logic [3:0]  pix_index;
   logic        frame_done;
   logic [11:0] rx_led_mask;
   logic        rx_err;

   ws2812b_rx_decoder #(.NUM_LEDS(12), .RESET_CYCLES(1600)) dut (
      .clk         (clk),
      .res_n       (res_n),
      .din         (din),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .pix_index   (pix_index),
      .frame_done  (frame_done),
      .rx_led_mask (rx_led_mask),
      .rx_err      (rx_err)
   );

   always #12.5 clk = ~clk;

   typedef struct packed {
      logic [23:0] d;
      logic [3:0]  i;
   } pix_t;

   pix_t        exp_pix[$];
   logic [11:0] exp_mask[$];
   pix_t        pe;
   int n_chk = 0, n_err = 0;
   int n_done = 0, exp_done = 0, n_err_seen = 0, exp_err = 0;
   logic [11:0] model_mask;
   logic [11:0] lit;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (pix_valid) begin
         check("pix_excl", {30'b0, rx_err, frame_done}, 32'h0);
         if (exp_pix.size() == 0) check("pix_unexpected", {31'b0, pix_valid}, 32'h0);
         else begin
            pe = exp_pix.pop_front();
            check("pix_data", {8'h0, pix_data}, {8'h0, pe.d});
            check("pix_index", {28'h0, pix_index}, {28'h0, pe.i});
         end
      end
      if (frame_done) begin
         n_done++;
         if (exp_mask.size() == 0) check("done_unexpected", {31'b0, frame_done}, 32'h0);
         else check("frame_mask", {20'h0, rx_led_mask}, {20'h0, exp_mask.pop_front()});
      end
      if (rx_err) n_err_seen++;
   end

   task automatic send_bit(input logic b, input int per);
      int th;
      th = b ? 32 : 16;
      for (int k = 0; k < per; k++) begin
         @(negedge clk);
         din = (k < th);
      end
   endtask

   task automatic send_pix(input logic [23:0] v, input int per);
      for (int k = 23; k >= 0; k--) send_bit(v[k], per);
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         din = 1'b0;
      end
   endtask

   // Expect a decoded pixel at position idx and fold it into the frame mask model.
   task automatic expect_pix(input logic [23:0] v, input int idx);
      exp_pix.push_back('{d: v, i: 4'((idx > 15) ? 15 : idx)});
      if (idx < 12 && v != 24'h0) model_mask[idx] = 1'b1;
   endtask

   task automatic expect_frame();
      exp_mask.push_back(model_mask);
      exp_done++;
      model_mask = '0;
   endtask

   task automatic end_checks(input string tag);
      check({tag, "_pix_left"}, 32'(exp_pix.size()), 32'h0);
      check({tag, "_done_cnt"}, 32'(n_done), 32'(exp_done));
      check({tag, "_err_cnt"}, 32'(n_err_seen), 32'(exp_err));
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_data"}, {8'h0, pix_data}, 32'h0);
      check({tag, "_index"}, {28'h0, pix_index}, 32'h0);
      check({tag, "_strobes"}, {29'h0, pix_valid, frame_done, rx_err}, 32'h0);
      check({tag, "_mask"}, {20'h0, rx_led_mask}, 32'h0);
   endtask

   initial begin
      #(25.0 * 95000);
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      model_mask = '0;
      din   = 1'b0;
      res_n = 1'b0;
      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      res_n = 1'b1;

      // Twelve pixels alternating green/black
      gap(1600);
      for (int i = 0; i < 12; i++) begin
         expect_pix((i % 2 == 0) ? 24'hFF0000 : 24'h000000, i);
         send_pix((i % 2 == 0) ? 24'hFF0000 : 24'h000000, 50);
      end
      expect_frame();
      gap(1700);
      end_checks("alt12");
      check("alt12_mask", {20'h0, rx_led_mask}, 32'h555);

      // Single pixel frame
      expect_pix(24'h00A5C3, 0);
      send_pix(24'h00A5C3, 50);
      expect_frame();
      gap(1700);
      end_checks("single");
      check("single_hold", {8'h0, pix_data}, 32'h00A5C3);

      // Short high pulse is an error; the following pixel is ignored until a gap
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         din = (k < 4);
      end
      exp_err++;
      send_pix(24'hFFFFFF, 50);
      gap(1700);
      end_checks("short");
      expect_pix(24'h123456, 0);
      send_pix(24'h123456, 50);
      expect_frame();
      gap(1700);
      end_checks("recover");

      // Truncated pixel: error, mask retained
      for (int k = 0; k < 12; k++) send_bit(1'b1, 50);
      exp_err++;
      gap(1700);
      end_checks("trunc");
      check("trunc_mask_hold", {20'h0, rx_led_mask}, 32'h001);
      gap(1700);

      // Transmitter-style frame: mask 0xA3C, GRB=101 at intensity 0x80
      lit = 12'hA3C;
      for (int i = 0; i < 12; i++) begin
         expect_pix(lit[i] ? 24'h800080 : 24'h000000, i);
         send_pix(lit[i] ? 24'h800080 : 24'h000000, 50);
      end
      expect_frame();
      gap(1700);
      end_checks("loop");
      check("loop_mask", {20'h0, rx_led_mask}, 32'hA3C);

      // Seventeen pixels: index saturates at 15, positions past 11 leave the mask alone
      for (int i = 0; i < 17; i++) begin
         expect_pix((i == 3 || i == 13 || i == 16) ? {8'(i), 16'h0F0F} : 24'h0, i);
         send_pix((i == 3 || i == 13 || i == 16) ? {8'(i), 16'h0F0F} : 24'h0, 40);
      end
      expect_frame();
      gap(1700);
      end_checks("sat");
      check("sat_mask", {20'h0, rx_led_mask}, 32'h008);

      // Reset in the middle of pixel 5
      for (int i = 0; i < 5; i++) begin
         expect_pix(24'h0000FF, i);
         send_pix(24'h0000FF, 50);
      end
      for (int k = 0; k < 10; k++) send_bit(1'b1, 50);
      @(negedge clk);
      res_n = 1'b0;
      @(negedge clk);
      check_zero_outputs("midrst");
      res_n = 1'b1;
      model_mask = '0;
      for (int k = 0; k < 14; k++) send_bit(1'b1, 50);
      gap(1700);
      end_checks("midrst_tail");
      expect_pix(24'hFFFFFF, 0);
      send_pix(24'hFFFFFF, 50);
      expect_frame();
      gap(1700);
      end_checks("after_rst");
      check("after_rst_mask", {20'h0, rx_led_mask}, 32'h001);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
